// File: rtl/operand_packer_16_if.sv
`default_nettype none
// ============================================================================
//  Module      : operand_packer_16_if
//  Description : Bundled input-word stream and packed-vector stream for the
//                16-lane operand packer. The slave modport is the packer's
//                view; the master modport is the view of whatever drives
//                words in and consumes vectors out.
//  Revision    : 1.0 - initial release
// ============================================================================
interface operand_packer_16_if #(
  parameter int DWIDTH = 16,
  parameter int LANES  = 16
);

  localparam int C_CNT_W = $clog2(LANES + 1);

  // Input word stream
  logic                     s_valid;
  logic                     s_ready;
  logic [DWIDTH-1:0]        s_data;
  logic                     s_last;

  // Packed vector stream
  logic                     m_valid;
  logic                     m_ready;
  logic [DWIDTH*LANES-1:0]  m_data;
  logic [C_CNT_W-1:0]       m_count;

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_count
  );

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_count
  );

endinterface
`default_nettype wire

// File: rtl/operand_packer_16.sv
`default_nettype none
// ============================================================================
//  Module      : operand_packer_16
//  Description : Serial-to-parallel operand collector. Gathers LANES words of
//                DWIDTH bits from a valid/ready stream into one packed
//                vector and hands it on through a second valid/ready stream.
//                Unfilled lanes are always zero so they are neutral for the
//                downstream adder tree.
//  Options     : OPERAND_PACKER_LAST_EN - when defined, s_last closes a
//                partial vector early (zero padded, m_count = words taken).
//                When undefined, s_last is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_packer_16 #(
  parameter int DWIDTH = 16,
  parameter int LANES  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  operand_packer_16_if.slave   bus
);

  localparam int                 C_CNT_W = $clog2(LANES + 1);
  localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(LANES - 1);
  localparam logic [C_CNT_W-1:0] C_ONE   = C_CNT_W'(1);

  // FULL is exactly m_valid; FILL collects words.
  typedef enum logic [0:0] {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t                       r_state;
  state_t                       w_state_next;
  logic [C_CNT_W-1:0]           r_cnt;
  logic [C_CNT_W-1:0]           w_cnt_next;
  logic [LANES-1:0][DWIDTH-1:0] r_lane;
  logic [LANES-1:0][DWIDTH-1:0] w_lane_next;

  logic w_s_ready;
  logic w_in_xfer;
  logic w_out_xfer;
  logic w_close;        // word accepted in FILL completes the vector
  logic w_first_close;  // word landing in lane 0 on a hand-off also closes

  // Accept while empty-handed, or while the pending vector leaves this cycle.
  assign w_s_ready  = (r_state == FILL) || bus.m_ready;
  assign w_in_xfer  = bus.s_valid && w_s_ready;
  assign w_out_xfer = (r_state == FULL) && bus.m_ready;

`ifdef OPERAND_PACKER_LAST_EN
  assign w_close       = bus.s_last || (r_cnt == C_LAST);
  assign w_first_close = bus.s_last;
`else
  logic w_unused_last;
  assign w_unused_last = bus.s_last;
  assign w_close       = (r_cnt == C_LAST);
  assign w_first_close = 1'b0;
`endif

  // Next-state, fill counter and lane contents.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_lane_next  = r_lane;
    case (r_state)
      FILL: begin
        if (w_in_xfer) begin
          for (int i = 0; i < LANES; i++) begin
            if (r_cnt == C_CNT_W'(i)) begin
              w_lane_next[i] = bus.s_data;
            end
          end
          w_cnt_next = r_cnt + C_ONE;
          if (w_close) begin
            w_state_next = FULL;
          end
        end
      end
      FULL: begin
        // Held completely stable until the vector is taken.
        if (w_out_xfer) begin
          w_lane_next  = '0;
          w_cnt_next   = '0;
          w_state_next = FILL;
          // Zero-bubble hand-off: the next word starts the next vector.
          if (w_in_xfer) begin
            w_lane_next[0] = bus.s_data;
            w_cnt_next     = C_ONE;
            if (w_first_close) begin
              w_state_next = FULL;
            end
          end
        end
      end
      default: begin
        w_state_next = FILL;
        w_cnt_next   = '0;
        w_lane_next  = '0;
      end
    endcase
  end

  // State, counter and lane registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FILL;
      r_cnt   <= '0;
      r_lane  <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_lane  <= w_lane_next;
    end
  end

  assign bus.s_ready = w_s_ready;
  assign bus.m_valid = (r_state == FULL);
  assign bus.m_count = (r_state == FULL) ? r_cnt : '0;
  assign bus.m_data  = r_lane;

endmodule
`default_nettype wire
